// File: rtl/shift_sequencer_24bits_pkg.sv
// Shared definitions for the mantissa shift sequencer: shift-register control
// codes, operation codes, FSM encoding and default datapath widths.
package shift_sequencer_24bits_pkg;

    localparam int DEF_WIDTH = 24;
    localparam int DEF_CNT_W = 5;

    localparam logic [1:0] SR_RIGHT = 2'b00;
    localparam logic [1:0] SR_LEFT  = 2'b01;
    localparam logic [1:0] SR_LOAD  = 2'b10;
    localparam logic [1:0] SR_HOLD  = 2'b11;

    localparam logic OP_ALIGN = 1'b0;
    localparam logic OP_NORM  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_sequencer_24bits.sv
// Sequencer for the 24-bit bidirectional mantissa shift register: align
// (right shift with sticky) and normalize (left shift until the MSB is set).
//
// Handshake: a request is accepted when start=1 and flush=0 while busy=0;
// done pulses for one cycle when results are valid and they stay valid until
// the next accepted start. flush squashes an in-flight operation with no done.
module shift_sequencer_24bits
    import shift_sequencer_24bits_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [CNT_W-1:0] shift_amount,
    input  logic [WIDTH-1:0] operand,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] shift_count,
    output logic             sticky,
    output logic             zero,
    output logic [1:0]       sr_control,
    output logic [WIDTH-1:0] sr_parallel_load,
    output logic             sr_msb,
    input  logic             sr_lsb,
    input  logic [WIDTH-1:0] sr_parallel_read,
    output state_t           state_dbg
);

    state_t           state_q, state_d;
    logic             op_q, op_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             sticky_q, sticky_d;
    logic             zero_q, zero_d;
    logic [CNT_W-1:0] amt_clamped;

    assign amt_clamped = (shift_amount > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : shift_amount;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_ALIGN;
            remaining_q <= '0;
            count_q     <= '0;
            sticky_q    <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            remaining_q <= remaining_d;
            count_q     <= count_d;
            sticky_q    <= sticky_d;
            zero_q      <= zero_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        remaining_d = remaining_q;
        count_d     = count_q;
        sticky_d    = sticky_q;
        zero_d      = zero_q;
        sr_control  = SR_HOLD;
        done        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !flush) begin
                    sr_control  = SR_LOAD;
                    state_d     = ST_SHIFT;
                    op_d        = op;
                    remaining_d = amt_clamped;
                    count_d     = '0;
                    sticky_d    = 1'b0;
                    zero_d      = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (op_q == OP_ALIGN) begin
                    if (remaining_q != '0) begin
                        // sr_lsb is the bit that leaves on this edge's right shift
                        sr_control  = SR_RIGHT;
                        sticky_d    = sticky_q | sr_lsb;
                        remaining_d = remaining_q - CNT_W'(1);
                        count_d     = count_q + CNT_W'(1);
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    if (sr_parallel_read == '0) begin
                        zero_d  = 1'b1;
                        state_d = ST_DONE;
                    end else if (sr_parallel_read[WIDTH-1]) begin
                        state_d = ST_DONE;
                    end else begin
                        sr_control = SR_LEFT;
                        count_d    = count_q + CNT_W'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                done    = !flush;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Keep the register frozen for the whole reset window, even if start is high
        if (reset) begin
            sr_control = SR_HOLD;
        end
    end

    assign busy             = (state_q != ST_IDLE);
    assign shift_count      = count_q;
    assign sticky           = sticky_q;
    assign zero             = zero_q;
    assign sr_parallel_load = operand;
    assign sr_msb           = 1'b0;
    assign state_dbg        = state_q;

endmodule

// File: tb/tb_shift_sequencer_24bits.sv
// Bench for shift_sequencer_24bits with a behavioural 24-bit shift register as its load.
module tb_shift_sequencer_24bits;
    import shift_sequencer_24bits_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [4:0]  shift_amount = '0;
    logic [23:0] operand = '0;
    logic        flush = 1'b0;
    logic        busy, done, sticky, zero, sr_msb, sr_lsb;
    logic [4:0]  shift_count;
    logic [1:0]  sr_control;
    logic [23:0] sr_parallel_load, sr_parallel_read;
    state_t      state_dbg;

    logic [23:0] sr_q = '0;

    int n_checks = 0;
    int n_fail = 0;

    logic [1:0] ctl_trace[$];
    logic [1:0] exp_q[$];

    typedef struct {
        logic        op;
        logic [4:0]  amount;
        logic [23:0] operand;
        logic [23:0] res;
        logic [4:0]  cnt;
        logic        st;
        logic        z;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    shift_sequencer_24bits dut (
        .clock            (clock),
        .reset            (reset),
        .start            (start),
        .op               (op),
        .shift_amount     (shift_amount),
        .operand          (operand),
        .flush            (flush),
        .busy             (busy),
        .done             (done),
        .shift_count      (shift_count),
        .sticky           (sticky),
        .zero             (zero),
        .sr_control       (sr_control),
        .sr_parallel_load (sr_parallel_load),
        .sr_msb           (sr_msb),
        .sr_lsb           (sr_lsb),
        .sr_parallel_read (sr_parallel_read),
        .state_dbg        (state_dbg)
    );

    // clock / reset-independent shift register load
    always #5 clock = ~clock;

    always @(posedge clock) begin
        case (sr_control)
            2'b00:   sr_q <= {sr_msb, sr_q[23:1]};
            2'b01:   sr_q <= {sr_q[22:0], 1'b0};
            2'b10:   sr_q <= sr_parallel_load;
            default: sr_q <= sr_q;
        endcase
    end

    assign sr_lsb           = sr_q[0];
    assign sr_parallel_read = sr_q;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one operation and follow it to its done pulse (bounded wait).
    task automatic do_op(input vec_t v, input int idx);
        int cyc;
        bit got;
        ctl_trace.delete();
        @(posedge clock); #1;
        start = 1'b1; op = v.op; shift_amount = v.amount; operand = v.operand;
        @(negedge clock);
        ctl_trace.push_back(sr_control);
        check($sformatf("v%0d_load_ctl", idx), 32'(sr_control), 32'(SR_LOAD));
        @(posedge clock); #1;
        start = 1'b0;
        cyc = 1;
        got = 1'b0;
        while (!got && cyc < 40) begin
            @(negedge clock);
            ctl_trace.push_back(sr_control);
            if (done) got = 1'b1;
            else begin
                @(posedge clock); #1;
                cyc++;
            end
        end
        check($sformatf("v%0d_done_seen", idx), 32'(got), 32'(1));
        check($sformatf("v%0d_latency", idx), 32'(cyc), 32'(v.lat));
        check($sformatf("v%0d_result", idx), 32'(sr_parallel_read), 32'(v.res));
        check($sformatf("v%0d_count", idx), 32'(shift_count), 32'(v.cnt));
        check($sformatf("v%0d_sticky", idx), 32'(sticky), 32'(v.st));
        check($sformatf("v%0d_zero", idx), 32'(zero), 32'(v.z));
        @(posedge clock); #1;
        @(negedge clock);
        check($sformatf("v%0d_done_one_cycle", idx), 32'(done), 32'(0));
        check($sformatf("v%0d_idle_after", idx), 32'(busy), 32'(0));
        check($sformatf("v%0d_count_held", idx), 32'(shift_count), 32'(v.cnt));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //          op        amt    operand      result       cnt    st    z     lat
        vecs[0] = '{OP_ALIGN, 5'd2,  24'hC00003, 24'h300000, 5'd2,  1'b1, 1'b0, 4};
        vecs[1] = '{OP_NORM,  5'd7,  24'h000100, 24'h800000, 5'd15, 1'b0, 1'b0, 17};
        vecs[2] = '{OP_NORM,  5'd7,  24'h000000, 24'h000000, 5'd0,  1'b0, 1'b1, 2};
        vecs[3] = '{OP_ALIGN, 5'd31, 24'h000001, 24'h000000, 5'd24, 1'b1, 1'b0, 26};
        vecs[4] = '{OP_ALIGN, 5'd4,  24'h123456, 24'h012345, 5'd4,  1'b1, 1'b0, 6};
        vecs[5] = '{OP_ALIGN, 5'd0,  24'h800000, 24'h800000, 5'd0,  1'b0, 1'b0, 2};
        vecs[6] = '{OP_NORM,  5'd0,  24'h800000, 24'h800000, 5'd0,  1'b0, 1'b0, 2};
        vecs[7] = '{OP_NORM,  5'd3,  24'h000001, 24'h800000, 5'd23, 1'b0, 1'b0, 25};
        vecs[8] = '{OP_ALIGN, 5'd5,  24'hABCDE0, 24'h055E6F, 5'd5,  1'b0, 1'b0, 7};
        vecs[9] = '{OP_NORM,  5'd0,  24'h0F0000, 24'hF00000, 5'd4,  1'b0, 1'b0, 6};

        // Reset with start held high: register must be left on hold
        start = 1'b1;
        repeat (2) @(negedge clock);
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_count", 32'(shift_count), 32'(0));
        check("rst_sticky", 32'(sticky), 32'(0));
        check("rst_zero", 32'(zero), 32'(0));
        check("rst_ctl_hold", 32'(sr_control), 32'(SR_HOLD));
        check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
        start = 1'b0;
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i], i);
            if (i == 0) begin
                exp_q = '{SR_LOAD, SR_RIGHT, SR_RIGHT, SR_HOLD, SR_HOLD};
                check("v0_trace_len", 32'(ctl_trace.size()), 32'(exp_q.size()));
                while (exp_q.size() > 0 && ctl_trace.size() > 0)
                    check("v0_ctl_seq", 32'(ctl_trace.pop_front()), 32'(exp_q.pop_front()));
            end
        end

        // Asynchronous reset in cycle 3 of an 8-shift align
        @(posedge clock); #1;
        start = 1'b1; op = OP_ALIGN; shift_amount = 5'd8; operand = 24'hFFFFFF;
        @(posedge clock); #1;
        start = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        @(negedge clock);
        check("mid_busy_before_rst", 32'(busy), 32'(1));
        check("mid_sticky_before_rst", 32'(sticky), 32'(1));
        #1 reset = 1'b1;
        #1;
        check("async_busy", 32'(busy), 32'(0));
        check("async_done", 32'(done), 32'(0));
        check("async_count", 32'(shift_count), 32'(0));
        check("async_sticky", 32'(sticky), 32'(0));
        check("async_ctl_hold", 32'(sr_control), 32'(SR_HOLD));
        @(negedge clock);
        reset = 1'b0;
        do_op(vecs[8], 18);

        // Flush during align; restarts in cycles 1-2 must be ignored
        @(posedge clock); #1;
        start = 1'b1; op = OP_ALIGN; shift_amount = 5'd10; operand = 24'h00F0F0;
        for (int c = 1; c <= 2; c++) begin
            @(posedge clock); #1;
            operand = 24'hFFFFFF; op = OP_NORM;
            @(negedge clock);
            check($sformatf("flush_restart_ignored_c%0d", c), 32'(sr_control), 32'(SR_RIGHT));
        end
        @(posedge clock); #1;
        start = 1'b0; flush = 1'b1;
        @(negedge clock);
        check("flush_ctl_hold", 32'(sr_control), 32'(SR_HOLD));
        check("flush_no_done_c3", 32'(done), 32'(0));
        @(posedge clock); #1;
        flush = 1'b0;
        @(negedge clock);
        check("flush_idle_c4", 32'(busy), 32'(0));
        check("flush_no_done_c4", 32'(done), 32'(0));
        check("flush_ctl_c4", 32'(sr_control), 32'(SR_HOLD));
        do_op(vecs[4], 14);

        // flush beats start in IDLE
        @(posedge clock); #1;
        start = 1'b1; flush = 1'b1; op = OP_ALIGN; shift_amount = 5'd3; operand = 24'h000007;
        @(negedge clock);
        check("idle_flush_ctl", 32'(sr_control), 32'(SR_HOLD));
        @(posedge clock); #1;
        start = 1'b0; flush = 1'b0;
        @(negedge clock);
        check("idle_flush_no_accept", 32'(busy), 32'(0));
        check("idle_flush_reg_kept", 32'(sr_parallel_read), 32'(24'h012345));
        check("sr_msb_zero", 32'(sr_msb), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
